wd_cfg_master: RTL and testbench

WD_CFG_MASTER -- requirements
Module: wd_cfg_master

---
 rtl/wd_cfg_master.sv | 170 +++++++++++++++++
 tb/tb_wd_cfg_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wd_cfg_master.sv
// APB master that programs and verifies a watchdog (start value + mode),
// then keeps it fed with periodic writes to the feed register.
module wd_cfg_master #(
  parameter logic [7:0] ADDR_START = 8'h00,
  parameter logic [7:0] ADDR_FEED  = 8'h04,
  parameter logic [7:0] ADDR_MODE  = 8'h08
) (
  input  logic        pclk,
  input  logic        prst,
  input  logic        cfg_start,
  input  logic [7:0]  cfg_value,
  input  logic [1:0]  cfg_mode,
  input  logic        feed_en,
  input  logic [15:0] feed_period,
  input  logic [7:0]  prdata,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [7:0]  paddr,
  output logic [7:0]  pwdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cfg_ok,
  output logic        feed_ovr,
  output logic [3:0]  state_dbg
);

  // APB handshake: no pready, so every transfer is a fixed setup cycle
  // (psel=1, penable=0) followed by one access cycle (psel=1, penable=1).
  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    WS_S   = 4'd1,
    WS_A   = 4'd2,
    WM_S   = 4'd3,
    WM_A   = 4'd4,
    RM_S   = 4'd5,
    RM_A   = 4'd6,
    RM_CAP = 4'd7,
    FD_S   = 4'd8,
    FD_A   = 4'd9
  } state_t;

  state_t      state;
  logic [7:0]  value_q;
  logic [1:0]  mode_q;
  logic [15:0] feed_cnt;
  logic        pending;

  logic count_on;
  logic expire;
  logic take_cfg;
  logic take_feed;

  always_comb begin
    count_on  = feed_en && cfg_ok && (feed_period != 16'd0);
    expire    = count_on && (feed_cnt == (feed_period - 16'd1));
    take_cfg  = (state == IDLE) && cfg_start;
    take_feed = (state == IDLE) && !cfg_start && pending;
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state    <= IDLE;
      value_q  <= 8'h00;
      mode_q   <= 2'b00;
      feed_cnt <= 16'd0;
      pending  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cfg_ok   <= 1'b0;
      feed_ovr <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      feed_ovr <= 1'b0;

      // A fresh expiry re-arms pending even in the cycle the old one is
      // consumed; only an expiry with an unconsumed pending is an overrun.
      if (take_cfg) begin
        feed_cnt <= 16'd0;
        pending  <= 1'b0;
      end else if (!count_on) begin
        feed_cnt <= 16'd0;
        pending  <= 1'b0;
      end else if (expire) begin
        feed_cnt <= 16'd0;
        pending  <= 1'b1;
        if (pending && !take_feed) feed_ovr <= 1'b1;
      end else begin
        feed_cnt <= feed_cnt + 16'd1;
        if (take_feed) pending <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cfg_start) begin
            value_q <= cfg_value;
            mode_q  <= cfg_mode;
            cfg_ok  <= 1'b0;
            state   <= WS_S;
          end else if (pending) begin
            state <= FD_S;
          end
        end
        WS_S: state <= WS_A;
        WS_A: state <= WM_S;
        WM_S: state <= WM_A;
        WM_A: state <= RM_S;
        RM_S: state <= RM_A;
        RM_A: state <= RM_CAP;
        RM_CAP: begin
          if (prdata == {6'b0, mode_q}) begin
            done   <= 1'b1;
            cfg_ok <= 1'b1;
          end else begin
            err <= 1'b1;
          end
          state <= IDLE;
        end
        FD_S: state <= FD_A;
        FD_A: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus outputs are a pure decode of the state register, so they change
  // only on clock edges.
  always_comb begin
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 8'h00;
    pwdata  = 8'h00;
    case (state)
      WS_S, WS_A: begin
        psel    = 1'b1;
        penable = (state == WS_A);
        pwrite  = 1'b1;
        paddr   = ADDR_START;
        pwdata  = value_q;
      end
      WM_S, WM_A: begin
        psel    = 1'b1;
        penable = (state == WM_A);
        pwrite  = 1'b1;
        paddr   = ADDR_MODE;
        pwdata  = {6'b0, mode_q};
      end
      RM_S, RM_A: begin
        psel    = 1'b1;
        penable = (state == RM_A);
        paddr   = ADDR_MODE;
      end
      FD_S, FD_A: begin
        psel    = 1'b1;
        penable = (state == FD_A);
        pwrite  = 1'b1;
        paddr   = ADDR_FEED;
        pwdata  = 8'h01;
      end
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_wd_cfg_master.sv
// Directed bench for wd_cfg_master: per-cycle vector table for the
// configuration sequences, hand-written sequences for feeding corner cases.
module tb_wd_cfg_master;

  logic        pclk;
  logic        prst;
  logic        cfg_start;
  logic [7:0]  cfg_value;
  logic [1:0]  cfg_mode;
  logic        feed_en;
  logic [15:0] feed_period;
  logic [7:0]  prdata;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr, pwdata;
  logic        busy, done, err, cfg_ok, feed_ovr;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Expected feed writes as {pwrite, paddr, pwdata}.
  logic [16:0] exp_q[$];

  wd_cfg_master dut (
    .pclk(pclk), .prst(prst), .cfg_start(cfg_start), .cfg_value(cfg_value),
    .cfg_mode(cfg_mode), .feed_en(feed_en), .feed_period(feed_period),
    .prdata(prdata), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .busy(busy), .done(done), .err(err),
    .cfg_ok(cfg_ok), .feed_ovr(feed_ovr), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic       cfg_start;
    logic [7:0] cfg_value;
    logic [1:0] cfg_mode;
    logic [7:0] prdata;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic       busy, done, err, cfg_ok;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic st, input logic [7:0] val,
                              input logic [1:0] md, input logic [7:0] prd,
                              input logic ps, input logic pe, input logic pw,
                              input logic [7:0] ad, input logic [7:0] wd,
                              input logic bz, input logic dn, input logic er,
                              input logic ok);
    vec_t v;
    v.cfg_start = st; v.cfg_value = val; v.cfg_mode = md; v.prdata = prd;
    v.psel = ps; v.penable = pe; v.pwrite = pw; v.paddr = ad; v.pwdata = wd;
    v.busy = bz; v.done = dn; v.err = er; v.cfg_ok = ok;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver tasks: inputs change and outputs are sampled 1 time unit after
  // each rising edge.
  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    prst = 1'b1;
    step();
    step();
    prst = 1'b0;
  endtask

  // Full good configuration; returns in the cycle done should be high.
  task automatic do_cfg(input logic [7:0] val, input logic [1:0] md);
    cfg_start = 1'b1;
    cfg_value = val;
    cfg_mode  = md;
    prdata    = {6'b0, md};
    step();
    cfg_start = 1'b0;
    repeat (7) step();
    chk("cfg_done", done, 1);
    chk("cfg_ok_set", cfg_ok, 1);
  endtask

  task automatic apb_monitor(input string tag);
    if (psel && !penable) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexp_write: got %0h expected none", tag, {pwrite, paddr, pwdata});
      end else begin
        chk({tag, "_write"}, {15'b0, pwrite, paddr, pwdata}, {15'b0, exp_q.pop_front()});
      end
    end
  endtask

  initial begin
    cfg_start   = 1'b0;
    cfg_value   = 8'h00;
    cfg_mode    = 2'b00;
    feed_en     = 1'b0;
    feed_period = 16'd0;
    prdata      = 8'h00;
    prst        = 1'b0;
    #1;
    do_reset();

    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {done, err, cfg_ok, feed_ovr}, 0);
    chk("rst_state", state_dbg, 0);

    // Config A: good readback. Config B: readback mismatch.
    vecs[0]  = mk(1, 8'h5A, 2'd2, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);
    vecs[1]  = mk(0, 8'hFF, 2'd3, 8'h00, 1, 0, 1, 8'h00, 8'h5A, 1, 0, 0, 0);
    vecs[2]  = mk(0, 8'hFF, 2'd3, 8'h00, 1, 1, 1, 8'h00, 8'h5A, 1, 0, 0, 0);
    vecs[3]  = mk(0, 8'hFF, 2'd3, 8'h00, 1, 0, 1, 8'h08, 8'h02, 1, 0, 0, 0);
    vecs[4]  = mk(0, 8'hFF, 2'd3, 8'h00, 1, 1, 1, 8'h08, 8'h02, 1, 0, 0, 0);
    vecs[5]  = mk(0, 8'hFF, 2'd3, 8'h00, 1, 0, 0, 8'h08, 8'h00, 1, 0, 0, 0);
    vecs[6]  = mk(0, 8'hFF, 2'd3, 8'h03, 1, 1, 0, 8'h08, 8'h00, 1, 0, 0, 0);
    vecs[7]  = mk(0, 8'hFF, 2'd3, 8'h02, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
    vecs[8]  = mk(0, 8'hFF, 2'd3, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 1, 0, 1);
    vecs[9]  = mk(0, 8'hFF, 2'd3, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1);
    vecs[10] = mk(1, 8'hC3, 2'd1, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 1);
    vecs[11] = mk(0, 8'h00, 2'd0, 8'h00, 1, 0, 1, 8'h00, 8'hC3, 1, 0, 0, 0);
    vecs[12] = mk(0, 8'h00, 2'd0, 8'h00, 1, 1, 1, 8'h00, 8'hC3, 1, 0, 0, 0);
    vecs[13] = mk(0, 8'h00, 2'd0, 8'h00, 1, 0, 1, 8'h08, 8'h01, 1, 0, 0, 0);
    vecs[14] = mk(0, 8'h00, 2'd0, 8'h00, 1, 1, 1, 8'h08, 8'h01, 1, 0, 0, 0);
    vecs[15] = mk(0, 8'h00, 2'd0, 8'h00, 1, 0, 0, 8'h08, 8'h00, 1, 0, 0, 0);
    vecs[16] = mk(0, 8'h00, 2'd0, 8'h01, 1, 1, 0, 8'h08, 8'h00, 1, 0, 0, 0);
    vecs[17] = mk(0, 8'h00, 2'd0, 8'h03, 0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0);
    vecs[18] = mk(0, 8'h00, 2'd0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0);
    vecs[19] = mk(0, 8'h00, 2'd0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      cfg_start = vecs[i].cfg_start;
      cfg_value = vecs[i].cfg_value;
      cfg_mode  = vecs[i].cfg_mode;
      prdata    = vecs[i].prdata;
      chk($sformatf("vec%0d_psel", i), psel, vecs[i].psel);
      chk($sformatf("vec%0d_penable", i), penable, vecs[i].penable);
      chk($sformatf("vec%0d_pwrite", i), pwrite, vecs[i].pwrite);
      chk($sformatf("vec%0d_paddr", i), paddr, vecs[i].paddr);
      chk($sformatf("vec%0d_pwdata", i), pwdata, vecs[i].pwdata);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("vec%0d_done", i), done, vecs[i].done);
      chk($sformatf("vec%0d_err", i), err, vecs[i].err);
      chk($sformatf("vec%0d_cfg_ok", i), cfg_ok, vecs[i].cfg_ok);
      step();
    end
    cfg_start = 1'b0;

    // After a mismatch nothing is fed even with feeding enabled.
    feed_en     = 1'b1;
    feed_period = 16'd10;
    for (int k = 0; k < 30; k++) begin
      chk("nofeed_psel", psel, 0);
      step();
    end
    feed_en = 1'b0;
    step();

    // Periodic feeding: feed_en rises at k=0 with counter at 0, so the
    // first feed setup is at k=11, then every 10 cycles.
    do_cfg(8'h33, 2'd2);
    feed_en     = 1'b1;
    feed_period = 16'd10;
    for (int m = 0; m < 5; m++) exp_q.push_back({1'b1, 8'h04, 8'h01});
    for (int k = 0; k < 60; k++) begin
      chk("feed_psel", psel, (k >= 11) && ((k % 10 == 1) || (k % 10 == 2)));
      chk("feed_penable", penable, (k >= 11) && (k % 10 == 2));
      apb_monitor("feed");
      step();
    end
    chk("feed_q_empty", exp_q.size(), 0);

    // k=60: feed pending in IDLE collides with cfg_start; config wins.
    cfg_start = 1'b1;
    cfg_value = 8'hA7;
    cfg_mode  = 2'd3;
    prdata    = 8'h03;
    chk("col_idle_psel", psel, 0);
    chk("col_ok_before", cfg_ok, 1);
    step();
    cfg_start = 1'b0;
    chk("col_ws_psel", psel, 1);
    chk("col_ws_penable", penable, 0);
    chk("col_ws_paddr", paddr, 8'h00);
    chk("col_ws_pwdata", pwdata, 8'hA7);
    chk("col_ok_cleared", cfg_ok, 0);
    repeat (3) step();
    cfg_start = 1'b1;
    chk("col_wma_penable", penable, 1);
    chk("col_wma_paddr", paddr, 8'h08);
    step();
    cfg_start = 1'b0;
    repeat (3) step();
    chk("col_done", done, 1);
    chk("col_ok", cfg_ok, 1);
    step();
    // The counter restarted with cfg_ok at k=68, so the next feed is at k=79.
    for (int k = 69; k < 79; k++) begin
      chk("col_no_restart_psel", psel, 0);
      chk("col_busy", busy, 0);
      step();
    end
    chk("refeed_psel", psel, 1);
    chk("refeed_paddr", paddr, 8'h04);
    chk("refeed_pwdata", pwdata, 8'h01);

    // Overrun with feed_period=1: expiry every cycle.
    feed_en     = 1'b0;
    feed_period = 16'd1;
    repeat (3) step();
    feed_en = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk("ovr_psel", psel, (k >= 2) && (k % 3 != 1));
      chk("ovr_feed_ovr", feed_ovr, (k >= 3) && (k % 3 != 2));
      step();
    end
    feed_en = 1'b0;
    step();
    step();
    chk("ovr_idle_busy", busy, 0);

    // Reset in the middle of the mode write.
    cfg_start = 1'b1;
    cfg_value = 8'h11;
    cfg_mode  = 2'd1;
    prdata    = 8'h01;
    step();
    cfg_start = 1'b0;
    repeat (3) step();
    chk("rstmid_wma_penable", penable, 1);
    chk("rstmid_wma_paddr", paddr, 8'h08);
    prst = 1'b1;
    step();
    prst = 1'b0;
    chk("rstmid_psel", psel, 0);
    chk("rstmid_penable", penable, 0);
    chk("rstmid_cfg_ok", cfg_ok, 0);
    chk("rstmid_state", state_dbg, 0);
    chk("rstmid_busy", busy, 0);
    step();
    chk("rstmid_stay_psel", psel, 0);
    chk("rstmid_stay_done", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
